// File: rtl/reorder_buffer_if.sv
// Dispatch, write-back commit and retire/flush signals of the reorder buffer.
// The buffer itself connects through the slave modport.
interface reorder_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int PHY_WIDTH  = 6,
    parameter int ROB_WIDTH  = 5,
    parameter int FIFO_DEPTH = 16
);
    localparam int SID_W = $clog2(FIFO_DEPTH);

    logic                  alloc_valid;
    logic                  alloc_rd_valid;
    logic [4:0]            alloc_rd_arch;
    logic [PHY_WIDTH-1:0]  alloc_rd_phy;
    logic [PHY_WIDTH-1:0]  alloc_old_phy;
    logic                  alloc_ready;
    logic [ROB_WIDTH-1:0]  alloc_rob_id;

    logic                  commit_alu_valid;
    logic [ROB_WIDTH-1:0]  commit_alu_rob_id;
    logic                  commit_load_valid;
    logic [ROB_WIDTH-1:0]  commit_load_rob_id;
    logic                  commit_store_valid;
    logic [ROB_WIDTH-1:0]  commit_store_rob_id;
    logic [SID_W-1:0]      commit_store_id;
    logic                  commit_branch_valid;
    logic [ROB_WIDTH-1:0]  commit_branch_rob_id;
    logic                  commit_mispredict;
    logic [ADDR_WIDTH-1:0] commit_actual_target;

    logic                  retire_valid;
    logic [ROB_WIDTH-1:0]  retire_rob_id;
    logic                  retire_rd_valid;
    logic [4:0]            retire_rd_arch;
    logic [PHY_WIDTH-1:0]  retire_rd_phy;
    logic [PHY_WIDTH-1:0]  retire_old_phy;
    logic                  retire_store_valid;
    logic [SID_W-1:0]      retire_store_id;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [ROB_WIDTH:0]    rob_count;

    modport master (
        output alloc_valid, alloc_rd_valid, alloc_rd_arch, alloc_rd_phy, alloc_old_phy,
        output commit_alu_valid, commit_alu_rob_id, commit_load_valid, commit_load_rob_id,
        output commit_store_valid, commit_store_rob_id, commit_store_id,
        output commit_branch_valid, commit_branch_rob_id, commit_mispredict, commit_actual_target,
        input  alloc_ready, alloc_rob_id,
        input  retire_valid, retire_rob_id, retire_rd_valid, retire_rd_arch, retire_rd_phy,
        input  retire_old_phy, retire_store_valid, retire_store_id, flush, redirect_pc, rob_count
    );

    modport slave (
        input  alloc_valid, alloc_rd_valid, alloc_rd_arch, alloc_rd_phy, alloc_old_phy,
        input  commit_alu_valid, commit_alu_rob_id, commit_load_valid, commit_load_rob_id,
        input  commit_store_valid, commit_store_rob_id, commit_store_id,
        input  commit_branch_valid, commit_branch_rob_id, commit_mispredict, commit_actual_target,
        output alloc_ready, alloc_rob_id,
        output retire_valid, retire_rob_id, retire_rd_valid, retire_rd_arch, retire_rd_phy,
        output retire_old_phy, retire_store_valid, retire_store_id, flush, redirect_pc, rob_count
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete out of order from four
// write-back buses, retire one entry per cycle from head, flush on mispredict.
module reorder_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int PHY_WIDTH  = 6,
    parameter int ROB_WIDTH  = 5,
    parameter int FIFO_DEPTH = 16
) (
    input logic             clk,
    input logic             rst,
    reorder_buffer_if.slave rob
);
    localparam int DEPTH = 2 ** ROB_WIDTH;
    localparam int SID_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic                  rd_valid;
        logic [4:0]            rd_arch;
        logic [PHY_WIDTH-1:0]  rd_phy;
        logic [PHY_WIDTH-1:0]  old_phy;
        logic                  is_store;
        logic [SID_W-1:0]      store_id;
        logic                  mispredict;
        logic [ADDR_WIDTH-1:0] target;
    } entry_t;

    entry_t               entries [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     done;
    logic [ROB_WIDTH:0]   head;
    logic [ROB_WIDTH:0]   tail;
    logic [ROB_WIDTH-1:0] head_idx;
    logic [ROB_WIDTH-1:0] tail_idx;
    logic                 full;
    logic                 alloc_fire;
    logic                 retire_fire;
    entry_t               head_entry;

    assign head_idx   = head[ROB_WIDTH-1:0];
    assign tail_idx   = tail[ROB_WIDTH-1:0];
    assign full       = (head[ROB_WIDTH] != tail[ROB_WIDTH]) && (head_idx == tail_idx);
    assign head_entry = entries[head_idx];

    // Full blocks allocation even if the head retires this cycle: no bypass.
    assign alloc_fire  = rob.alloc_valid && !full && !rob.flush;
    assign retire_fire = valid[head_idx] && done[head_idx] && !rob.flush;

    assign rob.alloc_ready  = !full;
    assign rob.alloc_rob_id = tail_idx;
    assign rob.rob_count    = tail - head;

    always_ff @(posedge clk) begin
        if (rst || rob.flush) begin
            valid                  <= '0;
            done                   <= '0;
            head                   <= '0;
            tail                   <= '0;
            rob.flush              <= 1'b0;
            rob.retire_valid       <= 1'b0;
            rob.retire_rd_valid    <= 1'b0;
            rob.retire_store_valid <= 1'b0;
            if (rst) begin
                rob.retire_rob_id   <= '0;
                rob.retire_rd_arch  <= '0;
                rob.retire_rd_phy   <= '0;
                rob.retire_old_phy  <= '0;
                rob.retire_store_id <= '0;
                rob.redirect_pc     <= '0;
            end
        end else begin
            rob.retire_valid       <= retire_fire;
            rob.retire_rd_valid    <= retire_fire && head_entry.rd_valid;
            rob.retire_store_valid <= retire_fire && head_entry.is_store;
            rob.flush              <= retire_fire && head_entry.mispredict;

            if (alloc_fire) begin
                valid[tail_idx] <= 1'b1;
                done[tail_idx]  <= 1'b0;
                tail            <= tail + 1'b1;
            end

            if (rob.commit_alu_valid && valid[rob.commit_alu_rob_id])
                done[rob.commit_alu_rob_id] <= 1'b1;
            if (rob.commit_load_valid && valid[rob.commit_load_rob_id])
                done[rob.commit_load_rob_id] <= 1'b1;
            if (rob.commit_store_valid && valid[rob.commit_store_rob_id])
                done[rob.commit_store_rob_id] <= 1'b1;
            if (rob.commit_branch_valid && valid[rob.commit_branch_rob_id])
                done[rob.commit_branch_rob_id] <= 1'b1;

            if (retire_fire) begin
                valid[head_idx]     <= 1'b0;
                head                <= head + 1'b1;
                rob.retire_rob_id   <= head_idx;
                rob.retire_rd_arch  <= head_entry.rd_arch;
                rob.retire_rd_phy   <= head_entry.rd_phy;
                rob.retire_old_phy  <= head_entry.old_phy;
                rob.retire_store_id <= head_entry.store_id;
                if (head_entry.mispredict)
                    rob.redirect_pc <= head_entry.target;
            end
        end
    end

    // NOTE: the payload array is deliberately not reset; valid/done alone decide liveness.
    always_ff @(posedge clk) begin
        if (!rst && !rob.flush) begin
            if (alloc_fire)
                entries[tail_idx] <= '{
                    rd_valid:   rob.alloc_rd_valid,
                    rd_arch:    rob.alloc_rd_arch,
                    rd_phy:     rob.alloc_rd_phy,
                    old_phy:    rob.alloc_old_phy,
                    is_store:   1'b0,
                    store_id:   '0,
                    mispredict: 1'b0,
                    target:     '0
                };
            if (rob.commit_store_valid && valid[rob.commit_store_rob_id]) begin
                entries[rob.commit_store_rob_id].is_store <= 1'b1;
                entries[rob.commit_store_rob_id].store_id <= rob.commit_store_id;
            end
            if (rob.commit_branch_valid && valid[rob.commit_branch_rob_id]) begin
                entries[rob.commit_branch_rob_id].mispredict <= rob.commit_mispredict;
                entries[rob.commit_branch_rob_id].target     <= rob.commit_actual_target;
            end
        end
    end
endmodule
